// File: rtl/uart_tx_feeder.sv
// Transmit buffer in front of the UART: the CPU pushes bytes into a FIFO, and a small
// poller drains them into the UART whenever its transmitter-empty flag is set.
module uart_tx_feeder #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        CE,
    input  logic        WR,
    input  logic        RD,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        UART_CE_SR,
    output logic        UART_CE_UART,
    output logic        UART_RD,
    output logic        UART_WR,
    output logic [31:0] UART_WriteData,
    input  logic [31:0] UART_ReadData
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL1,
        S_POLL2,
        S_CHECK,
        S_WRITE,
        S_GAP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_cnt_nxt;
    logic              tx_empty;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              overflow;

    logic              empty;
    logic              full;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              status_rd;
    logic              busy;
    logic [7:0]        count8;
    logic              unused_ok;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign push_req  = CE & WR;
    assign push_ok   = push_req & ~full;
    assign pop       = (state == S_WRITE);
    assign status_rd = CE & RD;
    assign busy      = (state != S_IDLE);
    assign count8    = 8'(count);
    assign unused_ok = &{1'b0, WriteData[31:8], UART_ReadData[31:1]};

    // Full is judged on the pre-edge count, so a push while full drops even if WRITE pops now.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full)
                overflow <= 1'b1;
            else if (status_rd)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (push_ok) mem[wr_ptr] <= WriteData[7:0];
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            gap_cnt  <= '0;
            tx_empty <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
            if (state == S_POLL2) tx_empty <= UART_ReadData[0];
        end
    end

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        case (state)
            S_IDLE:  if (!empty) state_nxt = S_POLL1;
            S_POLL1: state_nxt = S_POLL2;
            S_POLL2: state_nxt = S_CHECK;
            S_CHECK: state_nxt = tx_empty ? S_WRITE : S_POLL1;
            S_WRITE: begin
                state_nxt   = S_GAP;
                gap_cnt_nxt = GAP_LOAD;
            end
            S_GAP: begin
                if (gap_cnt == '0)
                    state_nxt = S_IDLE;
                else
                    gap_cnt_nxt = gap_cnt - 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // UART strobes decode straight from state so an async reset drops them at once.
    assign UART_CE_SR     = (state == S_POLL1) || (state == S_POLL2);
    assign UART_RD        = (state == S_POLL1) || (state == S_POLL2);
    assign UART_CE_UART   = (state == S_WRITE);
    assign UART_WR        = (state == S_WRITE);
    assign UART_WriteData = (state == S_WRITE) ? {24'h0, mem[rd_ptr]} : 32'h0;

    assign ReadData = status_rd ? {16'h0, count8, 4'h0, busy, overflow, full, empty} : 32'h0;

endmodule
